// File: rtl/arb16_pkg.sv
// Shared constants, FSM state type and rotate helpers for the 16-way
// round-robin arbiter.
package arb16_pkg;

    localparam int N    = 16;
    localparam int IDXW = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // A doubled vector turns the rotate into a plain shift plus a slice.
    function automatic logic [N-1:0] rotl16(input logic [N-1:0]    v,
                                            input logic [IDXW-1:0] s);
        logic [2*N-1:0] d;
        d = {v, v} << s;
        return d[2*N-1:N];
    endfunction

    function automatic logic [N-1:0] rotr16(input logic [N-1:0]    v,
                                            input logic [IDXW-1:0] s);
        logic [2*N-1:0] d;
        d = {v, v} >> s;
        return d[N-1:0];
    endfunction

endpackage

// File: rtl/onehot16_to_idx.sv
// Combinational 16-bit one-hot to 4-bit binary encoder; zero input gives 0.
module onehot16_to_idx
    import arb16_pkg::*;
(
    input  logic [N-1:0]    onehot,
    output logic [IDXW-1:0] idx
);

    // NOTE: idx gets a default before the loop so no path leaves it unassigned
    // (otherwise a latch is inferred).
    always_comb begin
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (onehot[i]) idx = idx | IDXW'(i);
        end
    end

endmodule

// File: rtl/rr_arb16_ctrl.sv
// 16-requester round-robin arbiter with registered one-hot grant and index.
// Define ARB_TIMEOUT_EN to add hold-time pre-emption after MAX_HOLD cycles.
module rr_arb16_ctrl #(
    parameter int N        = 16,
    parameter int IDXW     = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    output logic [N-1:0]    gnt,
    output logic [IDXW-1:0] gnt_idx,
    output logic            gnt_vld,
    output logic            preempt
);
    import arb16_pkg::*;

    if (N != 16 || IDXW != 4 || MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_cfg
        $error("rr_arb16_ctrl: unsupported N/IDXW/MAX_HOLD");
    end

    state_t          state;
    logic [IDXW-1:0] ptr;
    logic            owner_hold;
    logic            timeout;
    logic            rearb;
    logic [IDXW-1:0] search_ptr;
    logic [N-1:0]    search_req;
    logic [N-1:0]    rot_req;
    logic [N-1:0]    rot_win;
    logic [N-1:0]    nxt_gnt;
    logic [IDXW-1:0] nxt_idx;

    assign owner_hold = (state == BUSY) && req[gnt_idx];
    assign rearb      = !owner_hold || timeout;

    // A leaving owner moves the pointer past itself before the search, so the
    // same edge can hand the slot on without an idle bubble.
    assign search_ptr = (state == BUSY) ? gnt_idx + IDXW'(1) : ptr;
    assign search_req = req & ~gnt;

    // Rotate so the pointer sits at bit 0, keep the lowest set bit, rotate back.
    assign rot_req = rotr16(search_req, search_ptr);
    assign rot_win = rot_req & (~rot_req + N'(1));
    assign nxt_gnt = rotl16(rot_win, search_ptr);

    onehot16_to_idx u_enc (
        .onehot (nxt_gnt),
        .idx    (nxt_idx)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= '0;
            gnt     <= '0;
            gnt_idx <= '0;
            gnt_vld <= 1'b0;
        end else if (rearb) begin
            if (state == BUSY) ptr <= search_ptr;
            gnt     <= nxt_gnt;
            gnt_idx <= nxt_idx;
            gnt_vld <= |nxt_gnt;
            state   <= (|nxt_gnt) ? BUSY : IDLE;
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic [7:0] hold_cnt;
    logic       others_wait;

    assign others_wait = |search_req;
    assign timeout     = owner_hold && others_wait && (hold_cnt == 8'(MAX_HOLD - 1));

    // The counter restarts on every (re)arbitration, including idle cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
            preempt  <= 1'b0;
        end else begin
            preempt <= timeout;
            if (rearb) hold_cnt <= '0;
            else if (others_wait) hold_cnt <= hold_cnt + 8'd1;
        end
    end
`else
    assign timeout = 1'b0;
    assign preempt = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arb16_ctrl.sv
// Self-checking bench for rr_arb16_ctrl (default build): directed cases plus
// random traffic compared against a loop-based round-robin reference model.
module tb_rr_arb16_ctrl;

    logic        clk;
    logic        rst_n;
    logic [15:0] req;
    logic [15:0] gnt;
    logic [3:0]  gnt_idx;
    logic        gnt_vld;
    logic        preempt;

    int tests = 0;
    int fails = 0;

    // Reference model: current owner (-1 when idle) and search start point.
    int m_owner;
    int m_ptr;

    rr_arb16_ctrl dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld),
        .preempt (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
    endtask

    task automatic model_edge(input logic [15:0] r);
        bit found;
        if (m_owner >= 0 && !r[m_owner]) begin
            m_ptr   = (m_owner + 1) % 16;
            m_owner = -1;
        end
        if (m_owner < 0) begin
            found = 0;
            for (int i = 0; i < 16; i++) begin
                int k;
                k = (m_ptr + i) % 16;
                if (!found && r[k]) begin
                    m_owner = k;
                    found   = 1;
                end
            end
        end
    endtask

    task automatic check_model(input string tag);
        logic [15:0] eg;
        eg = (m_owner >= 0) ? (16'h0001 << m_owner) : 16'h0000;
        check({tag, ".gnt"},     32'(gnt),     32'(eg));
        check({tag, ".gnt_idx"}, 32'(gnt_idx), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
        check({tag, ".gnt_vld"}, 32'(gnt_vld), (m_owner >= 0) ? 32'd1 : 32'd0);
        check({tag, ".preempt"}, 32'(preempt), 32'd0);
        check({tag, ".onehot"},  32'($onehot0(gnt)), 32'd1);
    endtask

    task automatic step(input string tag, input logic [15:0] r);
        @(negedge clk);
        req = r;
        @(posedge clk);
        model_edge(r);
        #1;
        check_model(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = 16'h0000;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [15:0] r;

        // Reset held with every requester asserted: outputs stay idle.
        rst_n = 1'b0;
        req   = 16'hFFFF;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset.gnt",     32'(gnt),     32'h0);
        check("reset.gnt_vld", 32'(gnt_vld), 32'h0);
        check("reset.gnt_idx", 32'(gnt_idx), 32'h0);
        check("reset.preempt", 32'(preempt), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        model_edge(16'hFFFF);
        #1;
        check("post_reset.gnt", 32'(gnt),     32'h0001);
        check("post_reset.idx", 32'(gnt_idx), 32'h0);

        // Single request, one-cycle latency, then release to idle.
        do_reset();
        step("single", 16'h0400);
        check("single.idx", 32'(gnt_idx), 32'd10);
        step("single_drop", 16'h0000);
        check("single_drop.vld", 32'(gnt_vld), 32'd0);

        // Rotation with everyone requesting; owner drops for a single cycle.
        do_reset();
        step("rot_start", 16'hFFFF);
        for (int k = 0; k < 16; k++) begin
            step("rot_pass", 16'hFFFF & ~(16'h0001 << k));
            check("rot.idx", 32'(gnt_idx), 32'((k + 1) % 16));
            check("rot.vld", 32'(gnt_vld), 32'd1);
            step("rot_hold", 16'hFFFF);
            check("rot_hold.idx", 32'(gnt_idx), 32'((k + 1) % 16));
        end

        // Wrap-around skip: after serving 13 the search starts at 14.
        do_reset();
        step("wrap_13", 16'h2000);
        step("wrap_rel", 16'h0000);
        step("wrap_a", 16'h0005);
        check("wrap.first", 32'(gnt_idx), 32'd0);
        step("wrap_b", 16'h0004);
        check("wrap.second", 32'(gnt_idx), 32'd2);

        // Owner 3 drops while requester 1 rises on the same edge.
        do_reset();
        step("sim_own3", 16'h0008);
        step("sim_hold", 16'h0008);
        step("sim_swap", 16'h0002);
        check("sim.idx", 32'(gnt_idx), 32'd1);
        check("sim.gnt", 32'(gnt),     32'h0002);

        // Without the timeout feature a held grant is never pre-empted.
        do_reset();
        step("hold_own5", 16'h0020);
        for (int k = 0; k < 20; k++) begin
            step("hold_wait", 16'h0220);
            check("hold.gnt",     32'(gnt),     32'h0020);
            check("hold.preempt", 32'(preempt), 32'd0);
        end

        // Asynchronous reset in the middle of a grant.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_rst.gnt", 32'(gnt),     32'h0);
        check("async_rst.vld", 32'(gnt_vld), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        req   = 16'h0000;

        // Random traffic, biased so the current owner usually keeps requesting.
        for (int n = 0; n < 500; n++) begin
            r = 16'($urandom);
            if ($urandom_range(0, 2) == 0) r = r & 16'($urandom);
            if ($urandom_range(0, 15) == 0) r = 16'h0000;
            if (m_owner >= 0 && $urandom_range(0, 3) != 0) r[m_owner] = 1'b1;
            step("rand", r);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
